divergence_scheduler: RTL and testbench
=======================================

# divergence_scheduler

Per-core SIMT control-flow scheduler between the store stage and fetch. It consumes resolved control-flow events (JMP, split CJMP, HALT) carrying PCs and execution masks. It keeps the active (PC, mask) pair and a bounded divergence stack of deferred paths, and issues the next (PC, mask) to fetch through a valid/ready handshake. Paths reconverge when a redirect target matches the top-of-stack PC, and the core reports done once every path has halted.

## Interface
- MASK_W, 64, width of execution_mask_t (one bit per thread)
- ADDR_W, 64, PC width
- DEPTH, 8, divergence stack entries (power of two, ≥2)
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start_valid  in  1  launch request, honoured only in IDLE
- start_pc  in  ADDR_W  initial PC
- start_mask  in  MASK_W  initial thread mask
- evt_valid  in  1  control-flow event present
- evt_ready  out  1  event accepted this cycle when evt_valid & evt_ready
- evt_kind  in  2  0=JMP, 1=CJMP, 2=HALT, 3=reserved
- evt_pc0 / evt_pc1  in  ADDR_W  JMP/CJMP taken target / CJMP fall-through target
- evt_mask0 / evt_mask1  in  MASK_W  taken mask (HALT: halting threads) / fall-through mask
- fetch_valid  out  1  (fetch_pc, fetch_mask) valid; held until fetch_ready
- fetch_ready  in  1  fetch accepts the issue
- fetch_pc  out  ADDR_W  PC to fetch
- fetch_mask  out  MASK_W  execution mask for that PC
- depth  out  $clog2(DEPTH)+1  current stack occupancy
- done  out  1  all paths halted, stack empty; sticky until reset/start
- overflow  out  1  push attempted with stack full; sticky until reset

## Operation
- States: IDLE, ISSUE, RUN, DONE, ERROR. Reset → IDLE, all outputs 0, stack empty, cur_pc/cur_mask 0.
- IDLE: start_valid → cur=(start_pc,start_mask), done=0, go ISSUE. start_mask==0 → straight to DONE. start_valid ignored in all other states.
- ISSUE: fetch_valid=1 with cur; on fetch_ready → RUN.
- RUN: evt_ready=1. Accepted event:
  - JMP: cur=(evt_pc0, cur_mask) → REDIRECT.
  - CJMP, both masks nonzero: push (evt_pc1,evt_mask1); cur=(evt_pc0,evt_mask0) → REDIRECT (without the merge check). If full: overflow=1 → ERROR.
  - CJMP, one mask zero: behaves as JMP to the nonzero side's PC, with that side's mask.
  - CJMP, both masks zero: treated as HALT of all of cur_mask.
  - HALT: cur_mask &= ~evt_mask0. Nonzero → stay RUN, no issue. Zero → POP.
  - kind 3: ignored, no state change.
- REDIRECT (combinational merge check before entering ISSUE): if stack non-empty and top.pc == new cur_pc, pop, OR top.mask into cur_mask (reconvergence), check again against the new top (at most one merge per cycle; repeat next cycle). Then ISSUE.
- POP: stack non-empty → cur=top, pop → ISSUE. Empty → DONE, done=1.
- DONE: idle until start_valid (acts as IDLE start).
- ERROR: fetch_valid=0, evt_ready=0 until reset.
- Mask arithmetic is bitwise only. PCs are compared for full-width equality, with no wrap handling.

## Timing
- Event accepted at edge N → fetch_valid high at N+1; one extra cycle per additional merge.
- HALT to zero mask with non-empty stack → popped path on fetch at N+1. With empty stack → done=1 at N+1.
- start accepted at N → fetch_valid at N+1.
- evt_ready is 0 whenever fetch_valid=1 (no event overlap with a pending issue).
- fetch outputs are stable while fetch_valid & !fetch_ready.
- Push at depth==DEPTH-1 is legal (depth becomes DEPTH). Push at depth==DEPTH → overflow.
- Asynchronous reset mid-issue drops fetch_valid immediately and empties the stack. The cleared state holds until a new start.

## Test plan
- Launch: start pc=0x100, mask=0xFFFF_FFFF_FFFF_FFFF → fetch (0x100, all-ones) one cycle later; HALT mask all-ones → done=1, depth=0.
- Split/reconverge: CJMP pc0=0x200/mask0=0x0F, pc1=0x140/mask1=0xF0 → fetch (0x200,0x0F), depth=1. Then JMP pc0=0x140 → merge, fetch (0x140,0xFF), depth=0.
- Halt-pop: after the split above, HALT mask 0x0F → fetch (0x140,0xF0) next cycle. Then HALT 0xF0 → done=1.
- Degenerate CJMP: mask0=0, mask1=0x3 → fetch (pc1,0x3), depth unchanged. Both masks zero with empty stack → done=1.
- Overflow: DEPTH=8, 9 consecutive two-sided CJMPs → first 8 push (depth=8). 9th sets overflow=1; evt_ready and fetch_valid stay 0.
- Backpressure/reset: hold fetch_ready=0 for 5 cycles → fetch_pc/mask stable, evt_ready=0. Assert reset mid-hold → fetch_valid=0 that cycle, depth=0, state IDLE.

Source files
------------

// File: rtl/divergence_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : divergence_scheduler_if
// Description : Control-flow event channel (in) and fetch issue channel (out)
//               of the SIMT divergence scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface divergence_scheduler_if #(
    parameter int ADDR_W = 64,
    parameter int MASK_W = 64
);
    logic              evt_valid;
    logic              evt_ready;
    logic [1:0]        evt_kind;
    logic [ADDR_W-1:0] evt_pc0;
    logic [ADDR_W-1:0] evt_pc1;
    logic [MASK_W-1:0] evt_mask0;
    logic [MASK_W-1:0] evt_mask1;

    logic              fetch_valid;
    logic              fetch_ready;
    logic [ADDR_W-1:0] fetch_pc;
    logic [MASK_W-1:0] fetch_mask;

    // Store stage / fetch side: produces events, consumes issues
    modport master (
        output evt_valid, evt_kind, evt_pc0, evt_pc1, evt_mask0, evt_mask1,
        output fetch_ready,
        input  evt_ready, fetch_valid, fetch_pc, fetch_mask
    );

    // Scheduler side
    modport slave (
        input  evt_valid, evt_kind, evt_pc0, evt_pc1, evt_mask0, evt_mask1,
        input  fetch_ready,
        output evt_ready, fetch_valid, fetch_pc, fetch_mask
    );
endinterface
`default_nettype wire

// File: rtl/divergence_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : divergence_scheduler
// Description : Per-core SIMT control-flow scheduler. Tracks the active
//               (PC, mask), a bounded divergence stack of deferred paths,
//               reconverges on top-of-stack PC match and issues to fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module divergence_scheduler #(
    parameter int MASK_W = 64,
    parameter int ADDR_W = 64,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_valid,
    input  logic [ADDR_W-1:0]        start_pc,
    input  logic [MASK_W-1:0]        start_mask,
    divergence_scheduler_if.slave    bus,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     done,
    output logic                     overflow
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    localparam logic [1:0] c_K_JMP  = 2'd0;
    localparam logic [1:0] c_K_CJMP = 2'd1;
    localparam logic [1:0] c_K_HALT = 2'd2;

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_ISSUE = 3'd1;
    localparam logic [2:0] c_S_RUN   = 3'd2;
    localparam logic [2:0] c_S_REDIR = 3'd3;
    localparam logic [2:0] c_S_DONE  = 3'd4;
    localparam logic [2:0] c_S_ERROR = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] cur_pc_q, cur_pc_d;
    logic [MASK_W-1:0] cur_mask_q, cur_mask_d;
    logic [PW-1:0]     sp_q, sp_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic [ADDR_W-1:0] stk_pc_q   [DEPTH];
    logic [ADDR_W-1:0] stk_pc_d   [DEPTH];
    logic [MASK_W-1:0] stk_mask_q [DEPTH];
    logic [MASK_W-1:0] stk_mask_d [DEPTH];

    logic [IW-1:0]     w_top_idx;
    logic [IW-1:0]     w_sec_idx;
    logic              w_empty;
    logic              w_full;
    logic              w_redir;
    logic [ADDR_W-1:0] w_red_pc;
    logic [MASK_W-1:0] w_red_mask;
    logic              w_halt;
    logic [MASK_W-1:0] w_halt_mask;
    logic [MASK_W-1:0] w_left;

    // Stack pointers: top entry and the one beneath it (used to decide whether
    // another merge is pending after this cycle's merge)
    always_comb begin
        w_top_idx = sp_q[IW-1:0] - IW'(1);
        w_sec_idx = sp_q[IW-1:0] - IW'(2);
        w_empty   = (sp_q == '0);
        w_full    = (sp_q == PW'(DEPTH));
    end

    // State register and datapath flops; async reset clears everything
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= c_S_IDLE;
            cur_pc_q   <= '0;
            cur_mask_q <= '0;
            sp_q       <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stk_pc_q[i]   <= '0;
                stk_mask_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cur_pc_q   <= cur_pc_d;
            cur_mask_q <= cur_mask_d;
            sp_q       <= sp_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            for (int i = 0; i < DEPTH; i++) begin
                stk_pc_q[i]   <= stk_pc_d[i];
                stk_mask_q[i] <= stk_mask_d[i];
            end
        end
    end

    // Next-state: event decode, stack push/pop, reconvergence merge
    always_comb begin
        state_d     = state_q;
        cur_pc_d    = cur_pc_q;
        cur_mask_d  = cur_mask_q;
        sp_d        = sp_q;
        done_d      = done_q;
        ovf_d       = ovf_q;
        stk_pc_d    = stk_pc_q;
        stk_mask_d  = stk_mask_q;
        w_redir     = 1'b0;
        w_red_pc    = '0;
        w_red_mask  = '0;
        w_halt      = 1'b0;
        w_halt_mask = '0;
        w_left      = '0;

        case (state_q)
            c_S_IDLE, c_S_DONE: begin
                if (start_valid) begin
                    cur_pc_d   = start_pc;
                    cur_mask_d = start_mask;
                    sp_d       = '0;
                    if (start_mask == '0) begin
                        done_d  = 1'b1;
                        state_d = c_S_DONE;
                    end else begin
                        done_d  = 1'b0;
                        state_d = c_S_ISSUE;
                    end
                end
            end
            c_S_ISSUE: begin
                if (bus.fetch_ready) begin
                    state_d = c_S_RUN;
                end
            end
            c_S_RUN: begin
                if (bus.evt_valid) begin
                    case (bus.evt_kind)
                        c_K_JMP: begin
                            w_redir    = 1'b1;
                            w_red_pc   = bus.evt_pc0;
                            w_red_mask = cur_mask_q;
                        end
                        c_K_CJMP: begin
                            if (bus.evt_mask0 != '0 && bus.evt_mask1 != '0) begin
                                // True split: defer fall-through, no merge check
                                if (w_full) begin
                                    ovf_d   = 1'b1;
                                    state_d = c_S_ERROR;
                                end else begin
                                    stk_pc_d[sp_q[IW-1:0]]   = bus.evt_pc1;
                                    stk_mask_d[sp_q[IW-1:0]] = bus.evt_mask1;
                                    sp_d       = sp_q + PW'(1);
                                    cur_pc_d   = bus.evt_pc0;
                                    cur_mask_d = bus.evt_mask0;
                                    state_d    = c_S_ISSUE;
                                end
                            end else if (bus.evt_mask0 != '0) begin
                                w_redir    = 1'b1;
                                w_red_pc   = bus.evt_pc0;
                                w_red_mask = bus.evt_mask0;
                            end else if (bus.evt_mask1 != '0) begin
                                w_redir    = 1'b1;
                                w_red_pc   = bus.evt_pc1;
                                w_red_mask = bus.evt_mask1;
                            end else begin
                                w_halt      = 1'b1;
                                w_halt_mask = cur_mask_q;
                            end
                        end
                        c_K_HALT: begin
                            w_halt      = 1'b1;
                            w_halt_mask = bus.evt_mask0;
                        end
                        default: ;
                    endcase
                end
            end
            c_S_REDIR: begin
                w_redir    = 1'b1;
                w_red_pc   = cur_pc_q;
                w_red_mask = cur_mask_q;
            end
            default: ;
        endcase

        // Redirect: at most one merge per cycle; linger in REDIR while the
        // next entry down also targets the same PC
        if (w_redir) begin
            cur_pc_d   = w_red_pc;
            cur_mask_d = w_red_mask;
            state_d    = c_S_ISSUE;
            if (!w_empty && stk_pc_q[w_top_idx] == w_red_pc) begin
                cur_mask_d = w_red_mask | stk_mask_q[w_top_idx];
                sp_d       = sp_q - PW'(1);
                if (sp_q >= PW'(2) && stk_pc_q[w_sec_idx] == w_red_pc) begin
                    state_d = c_S_REDIR;
                end
            end
        end

        // Halt: retire threads; when none remain resume a deferred path
        if (w_halt) begin
            w_left     = cur_mask_q & ~w_halt_mask;
            cur_mask_d = w_left;
            if (w_left == '0) begin
                if (!w_empty) begin
                    cur_pc_d   = stk_pc_q[w_top_idx];
                    cur_mask_d = stk_mask_q[w_top_idx];
                    sp_d       = sp_q - PW'(1);
                    state_d    = c_S_ISSUE;
                end else begin
                    done_d  = 1'b1;
                    state_d = c_S_DONE;
                end
            end
        end
    end

    // Outputs decoded from the registered state only
    always_comb begin
        bus.fetch_valid = (state_q == c_S_ISSUE);
        bus.evt_ready   = (state_q == c_S_RUN);
        bus.fetch_pc    = cur_pc_q;
        bus.fetch_mask  = cur_mask_q;
        depth           = sp_q;
        done            = done_q;
        overflow        = ovf_q;
    end
endmodule
`default_nettype wire

// File: tb/tb_divergence_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_divergence_scheduler
// Description : Scoreboard bench for divergence_scheduler. Directed events;
//               expected fetch issues queued, a monitor checks handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divergence_scheduler;
    localparam int AW = 64;
    localparam int MW = 64;
    localparam int DP = 8;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [MW-1:0] mask;
        logic [3:0]    dep;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start_valid = 1'b0;
    logic [AW-1:0] start_pc = '0;
    logic [MW-1:0] start_mask = '0;
    logic [3:0]    depth;
    logic          done;
    logic          overflow;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    divergence_scheduler_if #(.ADDR_W(AW), .MASK_W(MW)) bus ();

    divergence_scheduler #(.MASK_W(MW), .ADDR_W(AW), .DEPTH(DP)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_pc    (start_pc),
        .start_mask  (start_mask),
        .bus         (bus.slave),
        .depth       (depth),
        .done        (done),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every fetch handshake is compared with the oldest expectation
    always @(negedge clk) begin
        if (!reset && bus.fetch_valid === 1'b1 && bus.fetch_ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL fetch_unexpected actual=%0h/%0h required=none",
                         bus.fetch_pc, bus.fetch_mask);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.fetch_pc !== e.pc || bus.fetch_mask !== e.mask || depth !== e.dep) begin
                    errors++;
                    $display("FAIL fetch actual=pc%0h/m%0h/d%0d required=pc%0h/m%0h/d%0d",
                             bus.fetch_pc, bus.fetch_mask, depth, e.pc, e.mask, e.dep);
                end
            end
        end
    end

    task automatic expect_fetch(input logic [AW-1:0] pc, input logic [MW-1:0] m, input int d);
        exp_t e;
        e.pc   = pc;
        e.mask = m;
        e.dep  = 4'(d);
        sb.push_back(e);
    endtask

    task automatic start(input logic [AW-1:0] pc, input logic [MW-1:0] m);
        @(posedge clk); #1;
        start_valid = 1'b1;
        start_pc    = pc;
        start_mask  = m;
        @(posedge clk); #1;
        start_valid = 1'b0;
    endtask

    // Wait (bounded) for evt_ready, present the event for one accepting edge
    task automatic send_evt(input logic [1:0] k, input logic [AW-1:0] p0, input logic [MW-1:0] m0,
                            input logic [AW-1:0] p1, input logic [MW-1:0] m1);
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.evt_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL evt_ready_timeout actual=0 required=1");
        end else begin
            bus.evt_valid = 1'b1;
            bus.evt_kind  = k;
            bus.evt_pc0   = p0;
            bus.evt_mask0 = m0;
            bus.evt_pc1   = p1;
            bus.evt_mask1 = m1;
            @(posedge clk); #1;
            bus.evt_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.evt_valid   = 1'b0;
        bus.evt_kind    = 2'd0;
        bus.evt_pc0     = '0;
        bus.evt_pc1     = '0;
        bus.evt_mask0   = '0;
        bus.evt_mask1   = '0;
        bus.fetch_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_fetch_valid", 128'(bus.fetch_valid), 128'd0);
        chk("rst_evt_ready", 128'(bus.evt_ready), 128'd0);
        chk("rst_depth", 128'(depth), 128'd0);
        chk("rst_done_ovf", 128'({done, overflow}), 128'd0);
        reset = 1'b0;

        // Launch and full halt
        expect_fetch(64'h100, '1, 0);
        start(64'h100, '1);
        send_evt(2'd2, '0, '1, '0, '0);
        chk("launch_done", 128'(done), 128'd1);
        chk("launch_depth", 128'(depth), 128'd0);

        // Split then reconverge via JMP to the deferred PC
        expect_fetch(64'h100, 64'hFF, 0);
        start(64'h100, 64'hFF);
        chk("restart_done_clr", 128'(done), 128'd0);
        expect_fetch(64'h200, 64'h0F, 1);
        send_evt(2'd1, 64'h200, 64'h0F, 64'h140, 64'hF0);
        expect_fetch(64'h140, 64'hFF, 0);
        send_evt(2'd0, 64'h140, '0, '0, '0);
        send_evt(2'd2, '0, 64'hFF, '0, '0);
        chk("merge_done", 128'(done), 128'd1);

        // Halt-pop
        expect_fetch(64'h100, 64'hFF, 0);
        start(64'h100, 64'hFF);
        expect_fetch(64'h200, 64'h0F, 1);
        send_evt(2'd1, 64'h200, 64'h0F, 64'h140, 64'hF0);
        expect_fetch(64'h140, 64'hF0, 0);
        send_evt(2'd2, '0, 64'h0F, '0, '0);
        send_evt(2'd2, '0, 64'hF0, '0, '0);
        chk("haltpop_done", 128'(done), 128'd1);

        // Degenerate CJMP, reserved kind, partial halt, both-zero CJMP
        expect_fetch(64'h300, 64'h3, 0);
        start(64'h300, 64'h3);
        expect_fetch(64'h340, 64'h3, 0);
        send_evt(2'd1, 64'h320, '0, 64'h340, 64'h3);
        send_evt(2'd3, 64'h999, 64'h3, 64'h999, 64'h3);
        chk("kind3_evt_ready", 128'(bus.evt_ready), 128'd1);
        chk("kind3_fetch_valid", 128'(bus.fetch_valid), 128'd0);
        send_evt(2'd2, '0, 64'h1, '0, '0);
        chk("partial_halt_ready", 128'(bus.evt_ready), 128'd1);
        chk("partial_halt_done", 128'(done), 128'd0);
        send_evt(2'd1, 64'h380, '0, 64'h390, '0);
        chk("zero_cjmp_done", 128'(done), 128'd1);

        // Double merge: two stacked entries share the reconvergence PC
        expect_fetch(64'h500, 64'hFF, 0);
        start(64'h500, 64'hFF);
        expect_fetch(64'h600, 64'h0F, 1);
        send_evt(2'd1, 64'h600, 64'h0F, 64'h700, 64'hF0);
        expect_fetch(64'h610, 64'h03, 2);
        send_evt(2'd1, 64'h610, 64'h03, 64'h700, 64'h0C);
        expect_fetch(64'h700, 64'hFF, 0);
        send_evt(2'd0, 64'h700, '0, '0, '0);
        send_evt(2'd2, '0, 64'hFF, '0, '0);
        chk("dblmerge_done", 128'(done), 128'd1);

        // Overflow: 8 pushes fill the stack, the 9th errors out
        expect_fetch(64'h800, 64'h3, 0);
        start(64'h800, 64'h3);
        for (int i = 0; i < DP; i++) begin
            expect_fetch(64'h900 + 64'(i * 16), 64'h1, i + 1);
            send_evt(2'd1, 64'h900 + 64'(i * 16), 64'h1, 64'hA00 + 64'(i * 16), 64'h2);
        end
        send_evt(2'd1, 64'hF00, 64'h1, 64'hF10, 64'h2);
        chk("ovf_flag", 128'(overflow), 128'd1);
        chk("ovf_depth", 128'(depth), 128'd8);
        repeat (3) @(posedge clk);
        #1;
        chk("err_evt_ready", 128'(bus.evt_ready), 128'd0);
        chk("err_fetch_valid", 128'(bus.fetch_valid), 128'd0);
        chk("err_ovf_sticky", 128'(overflow), 128'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("ovf_cleared", 128'(overflow), 128'd0);

        // Backpressure then asynchronous reset mid-hold
        expect_fetch(64'hB00, 64'hFF, 0);
        start(64'hB00, 64'hFF);
        @(posedge clk); #1;
        bus.fetch_ready = 1'b0;
        send_evt(2'd1, 64'hC00, 64'h0F, 64'hD00, 64'hF0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_fetch", {bus.fetch_valid, bus.fetch_pc[62:0], bus.fetch_mask},
                {1'b1, 63'hC00, 64'h0F});
            chk("hold_evt_ready_depth", 128'({bus.evt_ready, depth}), 128'({1'b0, 4'd1}));
        end
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_fetch_valid", 128'(bus.fetch_valid), 128'd0);
        chk("async_rst_depth", 128'(depth), 128'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.fetch_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after_rst", 128'({bus.fetch_valid, bus.evt_ready, done}), 128'd0);

        // Every queued expectation must have been consumed
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        chk("scoreboard_drained", 128'(sb.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
